// File: rtl/tpu_pkg.sv
// Shared TPU definitions: skew-feeder state encoding, default array size and
// the flush-length helper used to size the post-tile drain of the PE grid.
package tpu_pkg;

  typedef enum logic [1:0] {
    SKEW_IDLE   = 2'd0,
    SKEW_STREAM = 2'd1,
    SKEW_FLUSH  = 2'd2,
    SKEW_HOLD   = 2'd3
  } skew_state_e;

  localparam int DEFAULT_ARRAY_SIZE = 4;

  // A value entering lane 0 needs 2n-1 edges to reach the far corner PE.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/os_skew_feeder_if.sv
// Handshake and array-edge bundle of os_skew_feeder. master = upstream/drain side,
// slave = the feeder. lane_valid_o exists only with OS_SKEW_LANE_VALID_EN.
interface os_skew_feeder_if import tpu_pkg::*; #(
  parameter int ARRAY_SIZE    = DEFAULT_ARRAY_SIZE,
  parameter int DATA_WIDTH_IN = 16
);
  logic                                vec_valid_i;
  logic                                vec_ready_o;
  logic [ARRAY_SIZE*DATA_WIDTH_IN-1:0] vec_data_i;
  logic                                vec_last_i;
  logic [ARRAY_SIZE*DATA_WIDTH_IN-1:0] edge_data_o;
  logic                                clear_o;
  logic                                tile_done_o;
  logic                                result_taken_i;
  logic                                tile_err_o;
`ifdef OS_SKEW_LANE_VALID_EN
  logic [ARRAY_SIZE-1:0]               lane_valid_o;

  modport master (
    output vec_valid_i, vec_data_i, vec_last_i, result_taken_i,
    input  vec_ready_o, edge_data_o, clear_o, tile_done_o, tile_err_o, lane_valid_o
  );
  modport slave (
    input  vec_valid_i, vec_data_i, vec_last_i, result_taken_i,
    output vec_ready_o, edge_data_o, clear_o, tile_done_o, tile_err_o, lane_valid_o
  );
`else
  modport master (
    output vec_valid_i, vec_data_i, vec_last_i, result_taken_i,
    input  vec_ready_o, edge_data_o, clear_o, tile_done_o, tile_err_o
  );
  modport slave (
    input  vec_valid_i, vec_data_i, vec_last_i, result_taken_i,
    output vec_ready_o, edge_data_o, clear_o, tile_done_o, tile_err_o
  );
`endif
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one skew lane; output is the DEPTH-th tap.
// Async active-high reset clears every tap so a mid-tile reset leaves no stale data.
module skew_delay_line #(
  parameter int DEPTH         = 1,
  parameter int DATA_WIDTH_IN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH_IN-1:0] d,
  output logic [DATA_WIDTH_IN-1:0] q
);
  logic [DATA_WIDTH_IN-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];
endmodule

// File: rtl/os_skew_feeder.sv
// Diagonal-wavefront feeder for the output-stationary PE array: lane k delayed k cycles,
// tile sequencing (clear / stream / flush / hold). Optional macro: OS_SKEW_LANE_VALID_EN.
module os_skew_feeder import tpu_pkg::*; #(
  parameter int ARRAY_SIZE    = DEFAULT_ARRAY_SIZE,
  parameter int DATA_WIDTH_IN = 16,
  parameter int K_MAX         = 256
) (
  input logic           clk_i,
  input logic           rst_i,
  os_skew_feeder_if.slave bus
);
  localparam int FLUSH_CYCLES = flush_cycles(ARRAY_SIZE);
  localparam int FW           = $clog2(FLUSH_CYCLES);
  localparam int CW           = $clog2(K_MAX + 1);

  localparam logic [1:0] ST_IDLE   = SKEW_IDLE;
  localparam logic [1:0] ST_STREAM = SKEW_STREAM;
  localparam logic [1:0] ST_FLUSH  = SKEW_FLUSH;
  localparam logic [1:0] ST_HOLD   = SKEW_HOLD;

  logic [1:0]                          state;
  logic [FW-1:0]                       flush_cnt;
  logic [CW-1:0]                       beat_cnt;
  logic [CW-1:0]                       beat_num;
  logic                                ready;
  logic                                accept;
  logic                                force_last;
  logic                                end_beat;
  logic                                clear;
  logic                                done;
  logic                                err;
  logic [ARRAY_SIZE*DATA_WIDTH_IN-1:0] lane_in;
  logic [ARRAY_SIZE*DATA_WIDTH_IN-1:0] edge_data;

  assign ready      = (state == ST_IDLE) || (state == ST_STREAM);
  assign accept     = bus.vec_valid_i && ready;
  assign beat_num   = (state == ST_IDLE) ? CW'(1) : beat_cnt + CW'(1);
  assign force_last = (beat_num == CW'(K_MAX));
  assign end_beat   = accept && (bus.vec_last_i || force_last);
  // Bubbles, flush and hold all feed zeros so the MAC accumulators stay unchanged.
  assign lane_in    = accept ? bus.vec_data_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      beat_cnt  <= '0;
      clear     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            beat_cnt  <= beat_num;
            clear     <= 1'b0;
            flush_cnt <= '0;
            state     <= end_beat ? ST_FLUSH : ST_STREAM;
            if (force_last && !bus.vec_last_i) err <= 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
            done  <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.result_taken_i) begin
            state <= ST_IDLE;
            clear <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane k is k+1 registers deep: beat accepted at edge t shows on lane k after edge t+k.
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH         (k + 1),
      .DATA_WIDTH_IN (DATA_WIDTH_IN)
    ) u_data (
      .clk (clk_i),
      .rst (rst_i),
      .d   (lane_in[k*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
      .q   (edge_data[k*DATA_WIDTH_IN +: DATA_WIDTH_IN])
    );
`ifdef OS_SKEW_LANE_VALID_EN
    skew_delay_line #(
      .DEPTH         (k + 1),
      .DATA_WIDTH_IN (1)
    ) u_valid (
      .clk (clk_i),
      .rst (rst_i),
      .d   (accept),
      .q   (bus.lane_valid_o[k])
    );
`endif
  end

  assign bus.vec_ready_o = ready;
  assign bus.edge_data_o = edge_data;
  assign bus.clear_o     = clear;
  assign bus.tile_done_o = done;
  assign bus.tile_err_o  = err;
endmodule

// File: tb/tb_os_skew_feeder.sv
// Directed bench for os_skew_feeder: per-lane scoreboard of (due edge, value) entries
// pushed when a beat is driven and checked every cycle on the falling edge.
module tb_os_skew_feeder;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FC = 2 * N - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  os_skew_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH_IN(W)) bus ();
  os_skew_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH_IN(W)) bus_k ();

  os_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH_IN(W), .K_MAX(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  os_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH_IN(W), .K_MAX(8)) dut_k (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_k.slave)
  );

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } exp_t;

  exp_t lane_q [N][$];
  int   done_q [$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit           hit;
    logic [W-1:0] e;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      hit = (lane_q[k].size() > 0) && (lane_q[k][0].due == edge_n);
      e   = hit ? lane_q[k][0].val : '0;
      if (hit) void'(lane_q[k].pop_front());
      chk($sformatf("lane%0d@%0d", k, edge_n), 64'(bus.edge_data_o[k*W +: W]), 64'(e));
`ifdef OS_SKEW_LANE_VALID_EN
      chk($sformatf("lane_valid%0d@%0d", k, edge_n), 64'(bus.lane_valid_o[k]), 64'(hit));
`endif
    end
    hit = (done_q.size() > 0) && (done_q[0] == edge_n);
    if (hit) void'(done_q.pop_front());
    chk($sformatf("done@%0d", edge_n), 64'(bus.tile_done_o), 64'(hit));
  endtask

  task automatic beat(input int base, input int j, input bit last);
    bus.vec_valid_i = 1'b1;
    bus.vec_last_i  = last;
    for (int k = 0; k < N; k++) begin
      bus.vec_data_i[k*W +: W] = W'(base + j * N + k);
      lane_q[k].push_back('{due: edge_n + 1 + k, val: W'(base + j * N + k)});
    end
    if (last) done_q.push_back(edge_n + 1 + FC);
    chk($sformatf("ready_beat%0d", j), 64'(bus.vec_ready_o), 64'(1));
    tick();
    bus.vec_valid_i = 1'b0;
    bus.vec_last_i  = 1'b0;
  endtask

  // Invalid cycle with junk data and last set: both must be ignored.
  task automatic bubble();
    bus.vec_valid_i = 1'b0;
    bus.vec_last_i  = 1'b1;
    bus.vec_data_i  = '1;
    tick();
    bus.vec_last_i  = 1'b0;
  endtask

  task automatic release_hold();
    bus.result_taken_i = 1'b1;
    tick();
    bus.result_taken_i = 1'b0;
    chk("clear_after_taken", 64'(bus.clear_o), 64'(1));
    chk("ready_after_taken", 64'(bus.vec_ready_o), 64'(1));
  endtask

  initial begin
    bus.vec_valid_i      = 1'b0;
    bus.vec_last_i       = 1'b0;
    bus.vec_data_i       = '0;
    bus.result_taken_i   = 1'b0;
    bus_k.vec_valid_i    = 1'b0;
    bus_k.vec_last_i     = 1'b0;
    bus_k.vec_data_i     = '0;
    bus_k.result_taken_i = 1'b0;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_edge", 64'(bus.edge_data_o), 64'(0));
    chk("rst_clear", 64'(bus.clear_o), 64'(1));
    chk("rst_done", 64'(bus.tile_done_o), 64'(0));
    chk("rst_err", 64'(bus.tile_err_o), 64'(0));
    chk("rst_ready", 64'(bus.vec_ready_o), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    // Tile 1: continuous beats, last on beat 3
    chk("t1_clear_idle", 64'(bus.clear_o), 64'(1));
    beat(0, 0, 1'b0);
    chk("t1_clear_fell", 64'(bus.clear_o), 64'(0));
    beat(0, 1, 1'b0);
    beat(0, 2, 1'b0);
    beat(0, 3, 1'b1);
    chk("t1_ready_flush", 64'(bus.vec_ready_o), 64'(0));
    for (int i = 0; i < FC; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_hold_ready%0d", i), 64'(bus.vec_ready_o), 64'(0));
      chk($sformatf("t1_hold_clear%0d", i), 64'(bus.clear_o), 64'(0));
      tick();
    end
    release_hold();

    // Tile 2: bubble after beat 1; taken held high outside HOLD is ignored
    bus.result_taken_i = 1'b1;
    beat(100, 0, 1'b0);
    beat(100, 1, 1'b0);
    bubble();
    beat(99, 2, 1'b0);
    beat(99, 3, 1'b1);
    bus.result_taken_i = 1'b0;
    for (int i = 0; i < FC; i++) tick();
    tick();
    chk("t2_hold_ready", 64'(bus.vec_ready_o), 64'(0));
    chk("t2_err", 64'(bus.tile_err_o), 64'(0));
    release_hold();

    // Tile 3: asynchronous reset in the middle of FLUSH
    beat(200, 0, 1'b0);
    beat(200, 1, 1'b1);
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_edge", 64'(bus.edge_data_o), 64'(0));
    chk("midrst_clear", 64'(bus.clear_o), 64'(1));
    chk("midrst_done", 64'(bus.tile_done_o), 64'(0));
    chk("midrst_err", 64'(bus.tile_err_o), 64'(0));
    chk("midrst_ready", 64'(bus.vec_ready_o), 64'(1));
    for (int k = 0; k < N; k++) lane_q[k].delete();
    done_q.delete();
    tick();
    rst = 1'b0;

    // Tile 4: clean restart after reset
    beat(300, 0, 1'b0);
    chk("t4_clear_fell", 64'(bus.clear_o), 64'(0));
    beat(300, 1, 1'b0);
    beat(300, 2, 1'b0);
    beat(300, 3, 1'b1);
    for (int i = 0; i < FC; i++) tick();
    release_hold();

    // K_MAX = 8 instance: eight beats without last
    for (int j = 0; j < 8; j++) begin
      bus_k.vec_valid_i = 1'b1;
      bus_k.vec_last_i  = 1'b0;
      bus_k.vec_data_i  = {N{W'(j + 1)}};
      chk($sformatf("kmax_ready%0d", j), 64'(bus_k.vec_ready_o), 64'(1));
      if (j == 7) chk("kmax_err_before", 64'(bus_k.tile_err_o), 64'(0));
      tick();
    end
    bus_k.vec_valid_i = 1'b0;
    chk("kmax_err_set", 64'(bus_k.tile_err_o), 64'(1));
    chk("kmax_flush_ready", 64'(bus_k.vec_ready_o), 64'(0));
    for (int i = 1; i <= FC; i++) begin
      tick();
      chk($sformatf("kmax_done%0d", i), 64'(bus_k.tile_done_o), 64'(i == FC));
    end
    bus_k.result_taken_i = 1'b1;
    tick();
    bus_k.result_taken_i = 1'b0;
    chk("kmax_ready_idle", 64'(bus_k.vec_ready_o), 64'(1));
    chk("kmax_clear_idle", 64'(bus_k.clear_o), 64'(1));
    chk("kmax_err_sticky", 64'(bus_k.tile_err_o), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
